// File: rtl/clock_profile_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// clock_profile_sequencer_pkg
// Shared types for the clock profile sequencer and its profile table.
//   clk_cfg_t  : the three byte-wide clock generator settings of one profile.
//   state_t    : sequencer state (IDLE / RUN), values from ST_* constants.
//   PARK_CFG   : settings driven to the clock generator after an abort.
// The dwell field is held next to clk_cfg_t in the table rather than inside
// it, so its width can follow the DWELL_W parameter of the instantiating
// module (a package cannot be parameterised).
// -----------------------------------------------------------------------------
package clock_profile_sequencer_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN
  } state_t;

  typedef struct packed {
    logic [7:0] period_hi;
    logic [7:0] period_lo;
    logic [7:0] jitter;
  } clk_cfg_t;

  localparam clk_cfg_t PARK_CFG = '0;

endpackage

// File: rtl/clock_profile_sequencer_table.sv
// -----------------------------------------------------------------------------
// clock_profile_table
// Register array of N_PROFILE clock profiles with one synchronous write port
// and one combinational read port. Cleared by the asynchronous reset.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   wr_en, wr_addr      write strobe and entry index
//   wr_cfg, wr_dwell    profile settings and dwell written on the clk edge
//   rd_addr             entry to read (the sequencer's next index)
//   rd_cfg, rd_dwell    contents of entry rd_addr before any same-edge write
// -----------------------------------------------------------------------------
module clock_profile_table
  import clock_profile_sequencer_pkg::*;
#(
  parameter int N_PROFILE = 8,
  parameter int DWELL_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [$clog2(N_PROFILE)-1:0] wr_addr,
  input  clk_cfg_t                     wr_cfg,
  input  logic [DWELL_W-1:0]           wr_dwell,
  input  logic [$clog2(N_PROFILE)-1:0] rd_addr,
  output clk_cfg_t                     rd_cfg,
  output logic [DWELL_W-1:0]           rd_dwell
);

  clk_cfg_t           cfg_mem   [N_PROFILE];
  logic [DWELL_W-1:0] dwell_mem [N_PROFILE];
  logic [N_PROFILE-1:0] wr_sel;

  // One-hot entry select for the write port.
  for (genvar gi = 0; gi < N_PROFILE; gi++) begin : g_sel
    assign wr_sel[gi] = wr_en && (wr_addr == gi[$clog2(N_PROFILE)-1:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_PROFILE; i++) begin
        cfg_mem[i]   <= PARK_CFG;
        dwell_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_PROFILE; i++) begin
        if (wr_sel[i]) begin
          cfg_mem[i]   <= wr_cfg;
          dwell_mem[i] <= wr_dwell;
        end
      end
    end
  end

  // Combinational read: a load on the same edge as a write sees the old value.
  assign rd_cfg   = cfg_mem[rd_addr];
  assign rd_dwell = dwell_mem[rd_addr];

endmodule

// File: rtl/clock_profile_sequencer.sv
// -----------------------------------------------------------------------------
// clock_profile_sequencer
// Steps the clock generator through a programmed list of profiles. Each
// profile is applied for dwell+1 clock cycles; all outputs are registered.
// Optional feature (macro CLKSEQ_LOOP_EN): adds i_loop / o_wrap so the list
// repeats from entry 0 while i_loop is high at the end of the last profile.
// Ports:
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_cfgWrEn, i_cfgAddr,     profile table write port
//   i_cfgPeriodHi/Lo/Jitter,
//   i_cfgDwell
//   i_nProfiles               sequence length, sampled at start (clamped)
//   i_start, i_stop           start request / abort (stop has priority)
//   o_busy                    sequence running
//   o_done                    one-cycle pulse on normal completion
//   o_profileChange           one-cycle pulse when a profile is applied
//   o_profileIdx              index of applied profile
//   o_periodHi/Lo,
//   o_jitterControl           clock generator settings
//   i_loop, o_wrap            (CLKSEQ_LOOP_EN only) repeat enable / wrap pulse
// -----------------------------------------------------------------------------
module clock_profile_sequencer
  import clock_profile_sequencer_pkg::*;
#(
  parameter int N_PROFILE = 8,
  parameter int DWELL_W   = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_cfgWrEn,
  input  logic [$clog2(N_PROFILE)-1:0] i_cfgAddr,
  input  logic [7:0]                   i_cfgPeriodHi,
  input  logic [7:0]                   i_cfgPeriodLo,
  input  logic [7:0]                   i_cfgJitter,
  input  logic [DWELL_W-1:0]           i_cfgDwell,
  input  logic [$clog2(N_PROFILE):0]   i_nProfiles,
  input  logic                         i_start,
  input  logic                         i_stop,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_profileChange,
  output logic [$clog2(N_PROFILE)-1:0] o_profileIdx,
  output logic [7:0]                   o_periodHi,
  output logic [7:0]                   o_periodLo,
  output logic [7:0]                   o_jitterControl
`ifdef CLKSEQ_LOOP_EN
  ,
  input  logic                         i_loop,
  output logic                         o_wrap
`endif
);

  localparam int AW = $clog2(N_PROFILE);
  localparam int CW = AW + 1;

  state_t             state_reg;
  logic [CW-1:0]      n_latched_reg;
  logic [DWELL_W-1:0] dwell_cnt_reg;
  logic [AW-1:0]      idx_reg;
  clk_cfg_t           cfg_reg;
  logic               done_reg;
  logic               change_reg;
`ifdef CLKSEQ_LOOP_EN
  logic               wrap_reg;
`endif

  logic [CW-1:0]      n_clamped;
  logic               last_profile;
  logic [AW-1:0]      next_idx;
  clk_cfg_t           rd_cfg;
  logic [DWELL_W-1:0] rd_dwell;
  clk_cfg_t           wr_cfg;

  assign wr_cfg = '{period_hi: i_cfgPeriodHi, period_lo: i_cfgPeriodLo, jitter: i_cfgJitter};

  clock_profile_table #(
    .N_PROFILE (N_PROFILE),
    .DWELL_W   (DWELL_W)
  ) u_table (
    .clk      (i_clk),
    .rst      (i_rst),
    .wr_en    (i_cfgWrEn),
    .wr_addr  (i_cfgAddr),
    .wr_cfg   (wr_cfg),
    .wr_dwell (i_cfgDwell),
    .rd_addr  (next_idx),
    .rd_cfg   (rd_cfg),
    .rd_dwell (rd_dwell)
  );

  // Requests longer than the table run the whole table once.
  assign n_clamped = (i_nProfiles > CW'(N_PROFILE)) ? CW'(N_PROFILE) : i_nProfiles;

  assign last_profile = ({1'b0, idx_reg} == (n_latched_reg - CW'(1)));

  // The table is always addressed with the entry the next load would take:
  // entry 0 from IDLE or on a wrap, otherwise the following entry.
  always_comb begin
    next_idx = '0;
    if (state_reg == RUN && !last_profile) begin
      next_idx = idx_reg + AW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      n_latched_reg <= '0;
      dwell_cnt_reg <= '0;
      idx_reg       <= '0;
      cfg_reg       <= PARK_CFG;
      done_reg      <= 1'b0;
      change_reg    <= 1'b0;
`ifdef CLKSEQ_LOOP_EN
      wrap_reg      <= 1'b0;
`endif
    end else begin
      done_reg   <= 1'b0;
      change_reg <= 1'b0;
`ifdef CLKSEQ_LOOP_EN
      wrap_reg   <= 1'b0;
`endif
      unique case (state_reg)
        IDLE: begin
          if (i_start && !i_stop) begin
            if (n_clamped != '0) begin
              state_reg     <= RUN;
              n_latched_reg <= n_clamped;
              idx_reg       <= '0;
              cfg_reg       <= rd_cfg;
              dwell_cnt_reg <= rd_dwell;
              change_reg    <= 1'b1;
            end else begin
              // Empty sequence completes at once without touching outputs.
              done_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          if (i_stop) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            cfg_reg       <= PARK_CFG;
            dwell_cnt_reg <= '0;
          end else if (dwell_cnt_reg != '0) begin
            dwell_cnt_reg <= dwell_cnt_reg - DWELL_W'(1);
          end else if (!last_profile) begin
            idx_reg       <= next_idx;
            cfg_reg       <= rd_cfg;
            dwell_cnt_reg <= rd_dwell;
            change_reg    <= 1'b1;
`ifdef CLKSEQ_LOOP_EN
          end else if (i_loop) begin
            idx_reg       <= '0;
            cfg_reg       <= rd_cfg;
            dwell_cnt_reg <= rd_dwell;
            change_reg    <= 1'b1;
            wrap_reg      <= 1'b1;
`endif
          end else begin
            // Completion keeps the last profile on the outputs.
            state_reg <= IDLE;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_busy          = (state_reg == RUN);
  assign o_done          = done_reg;
  assign o_profileChange = change_reg;
  assign o_profileIdx    = idx_reg;
  assign o_periodHi      = cfg_reg.period_hi;
  assign o_periodLo      = cfg_reg.period_lo;
  assign o_jitterControl = cfg_reg.jitter;
`ifdef CLKSEQ_LOOP_EN
  assign o_wrap          = wrap_reg;
`endif

endmodule
